weight_control_unit_nbuf: RTL and testbench

Parametrised successor to the double-buffered weight control unit. Sequences row-by-row loading of weight tiles from the weight FIFO into an N-slot weight buffer in front of the MUL_SIZE x MUL_SIZE systolic array. Tracks complete tiles with an occupancy counter and read/write slot pointers. Sits between the weight FIFO and the MAC array / compute control unit.

---
 rtl/weight_control_unit_nbuf_pkg.sv | 20 ++
 rtl/weight_control_unit_nbuf_wbuf_ptr_ctrl.sv | 61 ++++++
 rtl/weight_control_unit_nbuf.sv | 125 ++++++++++++
 tb/tb_weight_control_unit_nbuf.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/weight_control_unit_nbuf_pkg.sv
// tpu_package: shared types and defaults for the weight buffering path.
//   MUL_SIZE_DEFAULT / NUM_WBUF_DEFAULT : default array size and slot count
//   weight_state_t                      : weight loader FSM states
//   slot_width()                        : slot pointer width, never below 1
package tpu_package;

    localparam int MUL_SIZE_DEFAULT = 8;
    localparam int NUM_WBUF_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } weight_state_t;

    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_control_unit_nbuf_wbuf_ptr_ctrl.sv
// wbuf_ptr_ctrl: modulo-NUM_BUF write/read slot pointers plus an occupancy
// counter for an N-slot tile buffer. Usable for weight or activation buffers.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : one tile completed (advance wr_ptr, count+1)
//   dec        : one tile consumed  (advance rd_ptr, count-1)
//   flush      : clear pointers and count; overrides inc/dec
//   wr_ptr     : slot being filled
//   rd_ptr     : slot holding the oldest complete tile
//   count      : complete tiles held (0..NUM_BUF)
// Callers must not inc when full or dec when empty (unless both together).
module wbuf_ptr_ctrl
    import tpu_package::*;
#(
    parameter  int NUM_BUF = NUM_WBUF_DEFAULT,
    localparam int SLOT_W  = slot_width(NUM_BUF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    input  logic              flush,
    output logic [SLOT_W-1:0] wr_ptr,
    output logic [SLOT_W-1:0] rd_ptr,
    output logic [SLOT_W:0]   count
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_BUF - 1);
    localparam logic [SLOT_W:0]   CNT_MAX   = (SLOT_W + 1)'(NUM_BUF);

    // Explicit wrap so non-power-of-2 slot counts work.
    function automatic logic [SLOT_W-1:0] wrap_inc(input logic [SLOT_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (inc) wr_ptr <= wrap_inc(wr_ptr);
            if (dec) rd_ptr <= wrap_inc(rd_ptr);
            case ({inc, dec})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (count <= CNT_MAX) && !(inc && !dec && !flush && count == CNT_MAX));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec && !inc && !flush && count == '0));

endmodule

// File: rtl/weight_control_unit_nbuf.sv
// weight_control_unit_nbuf: sequences row-by-row loading of weight tiles from
// the weight FIFO into an N-slot weight buffer ahead of the systolic array.
//   clk_i, rst_i                : clock, asynchronous active-low reset
//   load_en_i                   : permits starting tile loads
//   weight_fifo_valid_i         : FIFO has a row
//   weight_fifo_pop_o           : row accepted this cycle (combinational)
//   next_weight_tile_i          : compute side consumed the oldest tile
//   done_i                      : end of layer, flush everything
//   load_weights_o              : registered one-hot row strobe, MSB = row 0
//   wr_slot_o                   : slot accompanying load_weights_o
//   rd_slot_o                   : slot holding the oldest complete tile
//   tiles_buffered_o            : complete tiles held
//   compute_weights_rdy_o       : at least one tile held
//   compute_weights_buffered_o  : at least two tiles held
//   consume_err_o               : pulse, consume requested with nothing held
module weight_control_unit_nbuf
    import tpu_package::*;
#(
    parameter  int MUL_SIZE = MUL_SIZE_DEFAULT,
    parameter  int NUM_WBUF = NUM_WBUF_DEFAULT,
    localparam int ROW_W    = $clog2(MUL_SIZE),
    localparam int SLOT_W   = slot_width(NUM_WBUF)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_en_i,
    input  logic                weight_fifo_valid_i,
    output logic                weight_fifo_pop_o,
    input  logic                next_weight_tile_i,
    input  logic                done_i,
    output logic [MUL_SIZE-1:0] load_weights_o,
    output logic [SLOT_W-1:0]   wr_slot_o,
    output logic [SLOT_W-1:0]   rd_slot_o,
    output logic [SLOT_W:0]     tiles_buffered_o,
    output logic                compute_weights_rdy_o,
    output logic                compute_weights_buffered_o,
    output logic                consume_err_o
);

    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(MUL_SIZE - 1);
    localparam logic [SLOT_W:0]  ONE_SHORT  = (SLOT_W + 1)'(NUM_WBUF - 1);
    localparam logic [SLOT_W:0]  TWO_TILES  = (SLOT_W + 1)'(2);

    weight_state_t      state, state_nxt;
    logic [ROW_W-1:0]   row_cnt;
    logic [SLOT_W-1:0]  wr_ptr, rd_ptr;
    logic [SLOT_W:0]    tiles;
    logic               accept, tile_done, consume, consume_bad;

    // With load_en_i low a new tile is not started; a partial one is finished.
    assign accept      = (state == LOAD) && weight_fifo_valid_i &&
                         (load_en_i || (row_cnt != '0));
    assign tile_done   = accept && (row_cnt == LAST_ROW) && !done_i;
    assign consume     = next_weight_tile_i && (tiles != '0) && !done_i;
    assign consume_bad = next_weight_tile_i && (tiles == '0) && !done_i;

    assign weight_fifo_pop_o          = accept;
    assign rd_slot_o                  = rd_ptr;
    assign tiles_buffered_o           = tiles;
    assign compute_weights_rdy_o      = (tiles != '0);
    assign compute_weights_buffered_o = (tiles >= TWO_TILES);

    wbuf_ptr_ctrl #(.NUM_BUF(NUM_WBUF)) u_ptr (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .inc    (tile_done),
        .dec    (consume),
        .flush  (done_i),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (tiles)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (done_i) begin
            state_nxt = load_en_i ? LOAD : IDLE;
        end else begin
            case (state)
                IDLE: if (load_en_i) state_nxt = LOAD;
                LOAD: begin
                    if (tile_done) begin
                        // Full only if this completion is not offset by a consume.
                        if (!consume && tiles == ONE_SHORT) state_nxt = FULL;
                        else if (!load_en_i)                state_nxt = IDLE;
                    end else if (!load_en_i && row_cnt == '0) begin
                        state_nxt = IDLE;
                    end
                end
                FULL: if (consume) state_nxt = LOAD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            row_cnt        <= '0;
            load_weights_o <= '0;
            wr_slot_o      <= '0;
            consume_err_o  <= 1'b0;
        end else begin
            consume_err_o <= consume_bad;
            if (done_i) begin
                // Row popped alongside done_i is dropped.
                row_cnt        <= '0;
                load_weights_o <= '0;
            end else if (accept) begin
                // MUL_SIZE is a power of 2, so the counter wraps naturally and
                // ~row_cnt equals MUL_SIZE-1-row_cnt (row 0 drives the MSB).
                row_cnt        <= row_cnt + 1'b1;
                load_weights_o <= MUL_SIZE'(1) << (~row_cnt);
                wr_slot_o      <= wr_ptr;
            end else begin
                load_weights_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_weight_control_unit_nbuf.sv
module tb_weight_control_unit_nbuf;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic le = 1'b0, v = 1'b0, nt = 1'b0, dn = 1'b0;

    // Two-slot instance
    logic       pop2, rdy2, buf2, err2;
    logic [7:0] lw2;
    logic [0:0] wrs2, rds2;
    logic [1:0] tiles2;

    // Three-slot instance
    logic       pop3, rdy3, buf3, err3;
    logic [7:0] lw3;
    logic [1:0] wrs3, rds3;
    logic [2:0] tiles3;

    weight_control_unit_nbuf #(.MUL_SIZE(8), .NUM_WBUF(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .load_en_i(le), .weight_fifo_valid_i(v),
        .weight_fifo_pop_o(pop2), .next_weight_tile_i(nt), .done_i(dn),
        .load_weights_o(lw2), .wr_slot_o(wrs2), .rd_slot_o(rds2),
        .tiles_buffered_o(tiles2), .compute_weights_rdy_o(rdy2),
        .compute_weights_buffered_o(buf2), .consume_err_o(err2)
    );

    weight_control_unit_nbuf #(.MUL_SIZE(8), .NUM_WBUF(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .load_en_i(le), .weight_fifo_valid_i(v),
        .weight_fifo_pop_o(pop3), .next_weight_tile_i(nt), .done_i(dn),
        .load_weights_o(lw3), .wr_slot_o(wrs3), .rd_slot_o(rds3),
        .tiles_buffered_o(tiles3), .compute_weights_rdy_o(rdy3),
        .compute_weights_buffered_o(buf3), .consume_err_o(err3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit l, input bit vv, input bit n, input bit d);
        @(negedge clk);
        le = l; v = vv; nt = n; dn = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        le = 0; v = 0; nt = 0; dn = 0;
        rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    typedef struct {
        bit         le, v, nt, dn;
        bit         pop;     // pop during the cycle
        logic [7:0] lw;      // strobe after the edge
        int         slot;    // wr_slot after the edge (checked when lw != 0)
        int         tiles;   // tiles after the edge
    } vec_t;

    vec_t tbl[18];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] exp_lw;
        bit         vv;

        // Fill table: NUM_WBUF=2, valid held high, two full tiles then FULL.
        tbl[0] = '{1, 1, 0, 0, 0, 8'h00, 0, 0};
        for (int i = 0; i < 16; i++) begin
            exp_lw = 8'h80;
            exp_lw = exp_lw >> (i % 8);
            tbl[i + 1] = '{1, 1, 0, 0, 1, exp_lw, i / 8, (i + 1) / 8};
        end
        tbl[17] = '{1, 1, 0, 0, 0, 8'h00, 1, 2};

        // Reset state
        #3;
        chk("rst_lw", int'(lw2), 0);
        chk("rst_pop", int'(pop2), 0);
        chk("rst_tiles", int'(tiles2), 0);
        chk("rst_rdy", int'(rdy2), 0);
        chk("rst_buf", int'(buf2), 0);
        chk("rst_err", int'(err2), 0);
        chk("rst_wrs", int'(wrs2), 0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven run on the two-slot instance
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].le, tbl[i].v, tbl[i].nt, tbl[i].dn);
            chk($sformatf("tbl%0d_pop", i), int'(pop2), int'(tbl[i].pop));
            tick();
            chk($sformatf("tbl%0d_lw", i), int'(lw2), int'(tbl[i].lw));
            chk($sformatf("tbl%0d_tiles", i), int'(tiles2), tbl[i].tiles);
            chk($sformatf("tbl%0d_rdy", i), int'(rdy2), int'(tbl[i].tiles != 0));
            chk($sformatf("tbl%0d_buf", i), int'(buf2), int'(tbl[i].tiles >= 2));
            chk($sformatf("tbl%0d_rd", i), int'(rds2), 0);
            if (tbl[i].lw != 8'h00)
                chk($sformatf("tbl%0d_wrs", i), int'(wrs2), tbl[i].slot);
        end

        // NUM_WBUF=3: fill to FULL, consume, resume in wrapped slot 0
        do_reset();
        drive(1, 1, 0, 0); tick();
        repeat (24) begin drive(1, 1, 0, 0); tick(); end
        chk("full3_tiles", int'(tiles3), 3);
        drive(1, 1, 0, 0);
        chk("full3_pop", int'(pop3), 0);
        tick();
        chk("full3_lw", int'(lw3), 0);
        drive(1, 1, 1, 0);
        chk("full3_cons_pop", int'(pop3), 0);
        tick();
        chk("full3_cons_tiles", int'(tiles3), 2);
        chk("full3_cons_rd", int'(rds3), 1);
        drive(1, 1, 0, 0);
        chk("full3_resume_pop", int'(pop3), 1);
        tick();
        chk("full3_resume_lw", int'(lw3), 'h80);
        chk("full3_resume_wrs", int'(wrs3), 0);

        // Consume coincident with last-row accept, tiles=1
        do_reset();
        drive(1, 1, 0, 0); tick();
        repeat (15) begin drive(1, 1, 0, 0); tick(); end
        chk("coin_pre_tiles", int'(tiles3), 1);
        drive(1, 1, 1, 0); tick();
        chk("coin_tiles3", int'(tiles3), 1);
        chk("coin_rd3", int'(rds3), 1);
        chk("coin_tiles2", int'(tiles2), 1);
        chk("coin_rd2", int'(rds2), 1);
        drive(1, 1, 0, 0); tick();
        chk("coin_wrs3", int'(wrs3), 2);
        chk("coin_wrs2", int'(wrs2), 0);
        chk("coin_lw3", int'(lw3), 'h80);

        // done flush, then valid toggling
        drive(1, 0, 0, 1); tick();
        chk("flush_tiles", int'(tiles3), 0);
        chk("flush_rd", int'(rds3), 0);
        chk("flush_lw", int'(lw3), 0);
        for (int k = 0; k < 16; k++) begin
            vv = (k % 2 == 0);
            drive(1, vv, 0, 0);
            tick();
            exp_lw = 8'h80;
            exp_lw = vv ? (exp_lw >> (k / 2)) : 8'h00;
            chk($sformatf("tog%0d_lw", k), int'(lw3), int'(exp_lw));
            chk($sformatf("tog%0d_tiles", k), int'(tiles3), int'(k >= 14));
        end
        chk("tog_rdy", int'(rdy3), 1);

        // done mid-tile at row 4 with tiles=1; pop still asserted
        repeat (4) begin drive(1, 1, 0, 0); tick(); end
        drive(1, 1, 0, 1);
        chk("done_pop", int'(pop3), 1);
        tick();
        chk("done_tiles", int'(tiles3), 0);
        chk("done_rd", int'(rds3), 0);
        chk("done_lw", int'(lw3), 0);
        chk("done_rdy", int'(rdy3), 0);
        drive(1, 1, 0, 0); tick();
        chk("done_next_lw", int'(lw3), 'h80);
        chk("done_next_wrs", int'(wrs3), 0);

        // Consume with nothing buffered
        drive(1, 0, 1, 0); tick();
        chk("err_pulse", int'(err3), 1);
        chk("err_tiles", int'(tiles3), 0);
        chk("err_rd", int'(rds3), 0);
        drive(1, 0, 0, 0); tick();
        chk("err_clear", int'(err3), 0);

        // load_en dropped mid-tile: finish tile then IDLE
        do_reset();
        drive(1, 1, 0, 0); tick();
        repeat (3) begin drive(1, 1, 0, 0); tick(); end
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 0);
            chk($sformatf("len%0d_pop", k), int'(pop3), 1);
            tick();
        end
        chk("len_tiles", int'(tiles3), 1);
        drive(0, 1, 0, 0);
        chk("len_idle_pop", int'(pop3), 0);
        tick();
        chk("len_idle_lw", int'(lw3), 0);

        // Asynchronous reset mid-load
        drive(1, 1, 0, 0); tick();
        drive(1, 1, 0, 0); tick();
        chk("arst_pre_lw", int'(lw3), 'h80);
        #2 rst = 1'b0;
        #1;
        chk("arst_lw", int'(lw3), 0);
        chk("arst_pop", int'(pop3), 0);
        chk("arst_tiles", int'(tiles3), 0);
        chk("arst_rdy", int'(rdy3), 0);
        chk("arst_wrs", int'(wrs3), 0);
        #1 rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
